bp_initiator: RTL and testbench

//  BytePipe initiator: the host-side end of the BytePipe register protocol served by the correlator's register responder.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_initiator.sv | 166 ++++++++++++++++
 tb/tb_bp_initiator.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared BytePipe definitions: command byte layout, burst register address and
// the initiator FSM state codes.
package bp_pkg;

  localparam int BP_CMD_WR = 7;
  localparam int BP_ADDR_W = 7;
  localparam logic [BP_ADDR_W-1:0] BP_ADDR_BURST = 7'd0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BLEN_CMD = 3'd1;
  localparam logic [2:0] ST_BLEN_DAT = 3'd2;
  localparam logic [2:0] ST_BLEN_RSP = 3'd3;
  localparam logic [2:0] ST_CMD      = 3'd4;
  localparam logic [2:0] ST_WDAT     = 3'd5;
  localparam logic [2:0] ST_WRSP     = 3'd6;
  localparam logic [2:0] ST_RDAT     = 3'd7;

  function automatic logic [7:0] bp_cmd(input logic wr, input logic [BP_ADDR_W-1:0] addr);
    logic [7:0] c;
    c = {1'b0, addr};
    c[BP_CMD_WR] = wr;
    return c;
  endfunction

endpackage

// File: rtl/bp_initiator.sv
// BytePipe initiator: turns one rd/wr burst request into command/data bytes
// toward the register responder and collects its reply bytes.
module bp_initiator
  import bp_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [BP_ADDR_W-1:0] i_req_addr,
  input  logic [7:0]           i_req_len,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [7:0]           o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic                 o_done,
  output logic [7:0]           o_done_data,
  output logic [7:0]           o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  input  logic [7:0]           i_bp_data,
  input  logic                 i_bp_valid,
  output logic                 o_bp_ready
);

  logic [2:0]           state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic                 wr_q, wr_d;
  logic [BP_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic                 done_q, done_d;
  logic [7:0]           done_data_q, done_data_d;

  logic req_fire;
  logic bp_out_fire;
  logic bp_in_fire;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_bp_valid  = 1'b0;
    o_bp_data   = 8'h00;
    o_bp_ready  = 1'b0;
    o_wr_ready  = 1'b0;
    o_rd_valid  = 1'b0;
    o_rd_data   = 8'h00;
    case (state_q)
      ST_BLEN_CMD: begin
        o_bp_valid = 1'b1;
        o_bp_data  = bp_cmd(1'b1, BP_ADDR_BURST);
      end
      ST_BLEN_DAT: begin
        o_bp_valid = 1'b1;
        o_bp_data  = len_q;
      end
      ST_BLEN_RSP: o_bp_ready = 1'b1;
      ST_CMD: begin
        o_bp_valid = 1'b1;
        o_bp_data  = bp_cmd(wr_q, addr_q);
      end
      // Data phases are pure pass-throughs between the local stream and the link.
      ST_WDAT: begin
        o_bp_valid = i_wr_valid;
        o_bp_data  = i_wr_data;
        o_wr_ready = i_bp_ready;
      end
      ST_WRSP: o_bp_ready = 1'b1;
      ST_RDAT: begin
        o_rd_valid = i_bp_valid;
        o_rd_data  = i_bp_data;
        o_bp_ready = i_rd_ready;
      end
      default: ;
    endcase
  end

  assign req_fire    = i_req_valid && o_req_ready;
  assign bp_out_fire = o_bp_valid && i_bp_ready;
  assign bp_in_fire  = i_bp_valid && o_bp_ready;

  assign o_done      = done_q;
  assign o_done_data = done_data_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          wr_d    = i_req_wr;
          addr_d  = i_req_addr;
          // The burst register itself is always accessed as a single byte.
          len_d   = (i_req_addr == BP_ADDR_BURST) ? 8'd0 : i_req_len;
          state_d = (len_d != 8'd0) ? ST_BLEN_CMD : ST_CMD;
        end
      end
      ST_BLEN_CMD: if (bp_out_fire) state_d = ST_BLEN_DAT;
      ST_BLEN_DAT: if (bp_out_fire) state_d = ST_BLEN_RSP;
      ST_BLEN_RSP: if (bp_in_fire)  state_d = ST_CMD;
      ST_CMD: begin
        if (bp_out_fire) begin
          count_d = len_q;
          state_d = wr_q ? ST_WDAT : ST_RDAT;
        end
      end
      ST_WDAT: begin
        if (bp_out_fire) begin
          if (count_q == 8'd0) state_d = ST_WRSP;
          else                 count_d = count_q - 8'd1;
        end
      end
      ST_WRSP: begin
        if (bp_in_fire) begin
          done_data_d = i_bp_data;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RDAT: begin
        if (bp_in_fire) begin
          if (count_q == 8'd0) begin
            done_data_d = i_bp_data;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      count_q     <= 8'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      done_q      <= 1'b0;
      done_data_q <= 8'd0;
    end else if (i_cg) begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
    end
  end

endmodule

// File: tb/tb_bp_initiator.sv
// Bench for bp_initiator: a behavioural register responder on the link side,
// a request-level reference model feeding a scoreboard, and a decoupled monitor.
`timescale 1ns/1ps
module tb_bp_initiator;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cg = 1'b1;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic       i_req_wr = 1'b0;
  logic [6:0] i_req_addr = '0;
  logic [7:0] i_req_len = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_wr_valid = 1'b0;
  logic       o_wr_ready;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ready = 1'b1;
  logic       o_done;
  logic [7:0] o_done_data;
  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready = 1'b1;
  logic [7:0] i_bp_data = '0;
  logic       i_bp_valid = 1'b0;
  logic       o_bp_ready;

  bp_initiator dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_done(o_done), .o_done_data(o_done_data),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
    .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    int         nrd;
  } done_exp_t;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int issued = 0;
  int rd_beats = 0;

  logic [7:0] exp_bp_q[$];
  logic [7:0] exp_rd_q[$];
  done_exp_t  exp_done_q[$];
  logic [7:0] wr_src_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_regs[128];
  logic [7:0] rsp_regs[128];

  bit rnd_cg = 0, rnd_bp_ready = 0, rnd_bp_valid = 0, rnd_wr_valid = 0, rnd_rd_ready = 0;
  bit wr_hold = 0, rd_hold = 0;

  bit         rsp_wmode = 0;
  logic [6:0] rsp_addr = '0;
  int         rsp_left = 0;
  logic [7:0] rsp_reply = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h where nothing was expected at %0t", name, act, $time);
  endtask

  // Register file contents after reset: window-length exponent defaults to 32.
  task automatic model_reset();
    foreach (exp_regs[i]) exp_regs[i] = 8'h00;
    exp_regs[2] = 8'd32;
  endtask

  task automatic rsp_reset();
    foreach (rsp_regs[i]) rsp_regs[i] = 8'h00;
    rsp_regs[2] = 8'd32;
    resp_q.delete();
    rsp_wmode = 0;
  endtask

  // Responder: burst register (address 0) sizes the next transaction and is
  // consumed by any transaction to a non-zero address.
  task automatic rsp_consume(input logic [7:0] b);
    int n;
    int a;
    if (!rsp_wmode) begin
      n = int'(rsp_regs[0]) + 1;
      a = int'(b[6:0]);
      if (a != 0) rsp_regs[0] = 8'h00;
      if (b[7]) begin
        rsp_wmode = 1;
        rsp_addr  = b[6:0];
        rsp_left  = n;
        rsp_reply = rsp_regs[a];
      end else begin
        for (int i = 0; i < n; i++) resp_q.push_back(rsp_regs[(a + i) % 128]);
      end
    end else begin
      rsp_regs[rsp_addr] = b;
      rsp_addr = rsp_addr + 7'd1;
      rsp_left--;
      if (rsp_left == 0) begin
        resp_q.push_back(rsp_reply);
        rsp_wmode = 0;
      end
    end
  endtask

  // Reference model: the full link byte sequence, read stream and completion
  // value for one request, derived from the protocol rules.
  task automatic model_req(input logic wr, input logic [6:0] addr, input logic [7:0] len,
                           input logic [7:0] d0);
    int        eff;
    done_exp_t e;
    logic [7:0] d;
    eff = (addr == 7'd0) ? 0 : int'(len);
    if (eff != 0) begin
      exp_bp_q.push_back(8'h80);
      exp_bp_q.push_back(8'(eff));
    end
    exp_bp_q.push_back({wr, addr});
    if (wr) begin
      e.data = exp_regs[addr];
      e.nrd  = 0;
      for (int i = 0; i <= eff; i++) begin
        d = (i == 0) ? d0 : 8'($urandom);
        exp_bp_q.push_back(d);
        wr_src_q.push_back(d);
        exp_regs[int'(addr) + i] = d;
      end
    end else begin
      for (int i = 0; i <= eff; i++) exp_rd_q.push_back(exp_regs[int'(addr) + i]);
      e.data = exp_regs[int'(addr) + eff];
      e.nrd  = eff + 1;
    end
    exp_done_q.push_back(e);
  endtask

  // Link-side drivers, updated away from the active edge.
  always @(negedge i_clk) begin
    i_cg       = rnd_cg ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_bp_ready = rnd_bp_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (resp_q.size() > 0 && (!rnd_bp_valid || $urandom_range(0, 1) == 1)) begin
      i_bp_valid = 1'b1;
      i_bp_data  = resp_q[0];
    end else begin
      i_bp_valid = 1'b0;
      i_bp_data  = 8'h00;
    end
    if (wr_src_q.size() > 0 && !wr_hold && (!rnd_wr_valid || $urandom_range(0, 1) == 1)) begin
      i_wr_valid = 1'b1;
      i_wr_data  = wr_src_q[0];
    end else begin
      i_wr_valid = 1'b0;
      i_wr_data  = 8'h00;
    end
    i_rd_ready = rd_hold ? 1'b0 : (rnd_rd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Responder and write source: act on handshakes completing at the next edge.
  always @(negedge i_clk) begin
    #4;
    if (i_rst) begin
      rsp_reset();
      wr_src_q.delete();
    end else if (i_cg) begin
      if (o_bp_valid && i_bp_ready) rsp_consume(o_bp_data);
      if (i_wr_valid && o_wr_ready && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
      if (i_bp_valid && o_bp_ready && resp_q.size() > 0) void'(resp_q.pop_front());
    end
  end

  // Monitor: compares every DUT-side transfer against the scoreboard queues.
  always @(negedge i_clk) begin
    done_exp_t e;
    #4;
    if (i_rst) begin
      exp_bp_q.delete();
      exp_rd_q.delete();
      exp_done_q.delete();
      rd_beats = 0;
    end else if (i_cg) begin
      if (o_bp_valid && i_bp_ready) begin
        if (exp_bp_q.size() == 0) fail_now("bp_byte_unexpected", o_bp_data);
        else check("bp_byte", o_bp_data, exp_bp_q.pop_front());
      end
      if (o_rd_valid) check("rd_ready_passthru", o_bp_ready, i_rd_ready);
      if (o_rd_valid && i_rd_ready) begin
        rd_beats++;
        if (exp_rd_q.size() == 0) fail_now("rd_data_unexpected", o_rd_data);
        else check("rd_data", o_rd_data, exp_rd_q.pop_front());
      end
      if (o_done) begin
        if (exp_done_q.size() == 0) begin
          fail_now("done_unexpected", o_done_data);
        end else begin
          e = exp_done_q.pop_front();
          check("done_data", o_done_data, e.data);
          check("rd_beats", rd_beats, e.nrd);
        end
        rd_beats = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] len,
                       input logic [7:0] d0);
    bit acc;
    model_req(wr, addr, len, d0);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_wr    = wr;
    i_req_addr  = addr;
    i_req_len   = len;
    acc = 0;
    for (int c = 0; c < 1000; c++) begin
      #4;
      if (o_req_ready && i_cg) begin
        acc = 1;
        break;
      end
      @(negedge i_clk);
    end
    if (!acc) fail_now("req_accept_timeout", {24'd0, 1'b0, addr});
    else issued++;
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20000 && done_cnt < issued; c++) @(negedge i_clk);
    if (done_cnt < issued) fail_now("done_timeout", done_cnt);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    issued = done_cnt;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 1);
    check({tag, "_bp_valid"}, o_bp_valid, 0);
    check({tag, "_bp_ready"}, o_bp_ready, 0);
    check({tag, "_wr_ready"}, o_wr_ready, 0);
    check({tag, "_rd_valid"}, o_rd_valid, 0);
    check({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    model_reset();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #4;
    check_idle_outputs("reset");
    check("reset_done_data", o_done_data, 8'h00);

    // Read of the default window-length exponent.
    issue(1'b0, 7'd2, 8'd0, 8'h00);
    wait_done();

    // Single write with latency measurement from acceptance to done.
    issue(1'b1, 7'd6, 8'd0, 8'h05);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      #4;
      lat++;
      if (o_done) break;
      @(negedge i_clk);
    end
    check("wr_latency", lat, 4);
    wait_done();

    // Burst read of four bytes.
    issue(1'b0, 7'd1, 8'd3, 8'h00);
    wait_done();

    // Burst write with a bursty data source and a stalling link.
    rnd_wr_valid = 1;
    rnd_bp_ready = 1;
    issue(1'b1, 7'd7, 8'd2, 8'hA5);
    wait_done();
    rnd_wr_valid = 0;
    rnd_bp_ready = 0;

    // Read sink stalled: the reply must stay on the link until it is taken.
    rd_hold = 1;
    issue(1'b0, 7'd2, 8'd0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      #4;
      check("rd_hold_bp_ready", o_bp_ready, 0);
    end
    rd_hold = 0;
    wait_done();

    // Address 0 ignores the requested length.
    issue(1'b0, 7'd0, 8'd5, 8'h00);
    issue(1'b1, 7'd0, 8'd9, 8'h00);
    issue(1'b1, 7'd40, 8'd20, 8'h11);
    issue(1'b0, 7'd40, 8'd20, 8'h00);
    wait_done();

    // Randomised back-to-back traffic with clock gating and throttled peers.
    rnd_cg = 1; rnd_bp_ready = 1; rnd_bp_valid = 1; rnd_wr_valid = 1; rnd_rd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      logic wr;
      int   len;
      int   addr;
      wr   = 1'($urandom_range(0, 1));
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(0, 3));
      addr = int'($urandom_range(1, 127 - len));
      issue(wr, 7'(addr), 8'(len), 8'($urandom));
    end
    wait_done();
    rnd_cg = 0; rnd_bp_ready = 0; rnd_bp_valid = 0; rnd_wr_valid = 0; rnd_rd_ready = 0;

    // Reset while parked in the write-data phase, then a clean transaction.
    wr_hold = 1;
    issue(1'b1, 7'd9, 8'd0, 8'hAA);
    repeat (3) @(negedge i_clk);
    #4;
    check("wdat_wr_ready", o_wr_ready, 1);
    check("wdat_bp_valid", o_bp_valid, 0);
    do_reset();
    wr_hold = 0;
    #4;
    check_idle_outputs("midrst");
    issue(1'b1, 7'd9, 8'd1, 8'h3C);
    issue(1'b0, 7'd9, 8'd1, 8'h00);
    wait_done();

    repeat (5) @(negedge i_clk);
    check("end_bp_q_empty", exp_bp_q.size(), 0);
    check("end_rd_q_empty", exp_rd_q.size(), 0);
    check("end_done_q_empty", exp_done_q.size(), 0);
    check("end_wr_src_empty", wr_src_q.size(), 0);
    check("end_done_count", done_cnt, issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
